bank_cmd_arbiter: RTL and testbench

BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

---
 rtl/bank_cmd_arbiter.sv | 134 +++++++++++++
 tb/tb_bank_cmd_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_arbiter.sv
// Round-robin command arbiter for bank-level requesters sharing one DRAM command bus.
// Grants are combinational; the selected command is registered onto the bus one cycle later.
module bank_cmd_arbiter #(
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned TRRD     = 4,
    parameter int unsigned TWTR     = 6,
    parameter int unsigned TRTW     = 4,
    localparam int unsigned BANK_W  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BANK-1:0]          req_valid,
    input  logic [2*NUM_BANK-1:0]        req_cmd,
    input  logic [ADDR_W*NUM_BANK-1:0]   req_addr,
    input  logic                         block,
    output logic [NUM_BANK-1:0]          req_ready,
    output logic                         cmd_valid,
    output logic [1:0]                   cmd_code,
    output logic [BANK_W-1:0]            cmd_bank,
    output logic [ADDR_W-1:0]            cmd_addr
);

    localparam int unsigned MAX_T_A = (TRRD > TWTR) ? TRRD : TWTR;
    localparam int unsigned MAX_T   = (MAX_T_A > TRTW) ? MAX_T_A : TRTW;
    localparam int unsigned CNT_W   = $clog2(MAX_T + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;

    logic [CNT_W-1:0]   r_act_cnt;
    logic [CNT_W-1:0]   r_wtr_cnt;
    logic [CNT_W-1:0]   r_rtw_cnt;
    logic [BANK_W-1:0]  r_ptr;

    logic [1:0]         w_cmd  [NUM_BANK];
    logic [ADDR_W-1:0]  w_addr [NUM_BANK];
    logic [NUM_BANK-1:0] w_elig;
    logic               w_found;
    logic [BANK_W-1:0]  w_gidx;
    int unsigned        w_idx;
    logic [1:0]         w_gcmd;
    logic [ADDR_W-1:0]  w_gaddr;
    logic [BANK_W-1:0]  w_next_ptr;

    // Unpack per-bank fields and decide which requests satisfy the turnaround timers.
    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
        assign w_cmd[gi]  = req_cmd[2*gi +: 2];
        assign w_addr[gi] = req_addr[ADDR_W*gi +: ADDR_W];

        always_comb begin
            w_elig[gi] = 1'b1;
            case (w_cmd[gi])
                CMD_ACT: w_elig[gi] = (r_act_cnt == '0);
                CMD_RD:  w_elig[gi] = (r_wtr_cnt == '0);
                CMD_WR:  w_elig[gi] = (r_rtw_cnt == '0);
                default: w_elig[gi] = 1'b1;
            endcase
        end
    end

    // Search upward from the pointer; ineligible requests are simply passed over.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_BANK; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_BANK) begin
                w_idx = w_idx - NUM_BANK;
            end
            if (!w_found && req_valid[BANK_W'(w_idx)] && w_elig[BANK_W'(w_idx)]) begin
                w_found = 1'b1;
                w_gidx  = BANK_W'(w_idx);
            end
        end
        if (!rst_n || block) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_found) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    assign w_gcmd     = w_cmd[w_gidx];
    assign w_gaddr    = w_addr[w_gidx];
    assign w_next_ptr = (w_gidx == BANK_W'(NUM_BANK - 1)) ? '0 : w_gidx + BANK_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            r_ptr     <= '0;
            r_act_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
        end else begin
            cmd_valid <= w_found;
            if (w_found) begin
                cmd_code <= w_gcmd;
                cmd_bank <= w_gidx;
                cmd_addr <= w_gaddr;
                r_ptr    <= w_next_ptr;
            end

            // Timers keep running during block so maintenance windows count toward spacing.
            if (w_found && w_gcmd == CMD_ACT) begin
                r_act_cnt <= CNT_W'(TRRD - 1);
            end else if (r_act_cnt != '0) begin
                r_act_cnt <= r_act_cnt - CNT_W'(1);
            end

            if (w_found && w_gcmd == CMD_WR) begin
                r_wtr_cnt <= CNT_W'(TWTR - 1);
            end else if (r_wtr_cnt != '0) begin
                r_wtr_cnt <= r_wtr_cnt - CNT_W'(1);
            end

            if (w_found && w_gcmd == CMD_RD) begin
                r_rtw_cnt <= CNT_W'(TRTW - 1);
            end else if (r_rtw_cnt != '0) begin
                r_rtw_cnt <= r_rtw_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed corner scenarios followed by random traffic,
// with a cycle-stamped reference model feeding a scoreboard on the command bus.
module tb_bank_cmd_arbiter;

    localparam int NB   = 4;
    localparam int AW   = 14;
    localparam int TRRD = 4;
    localparam int TWTR = 6;
    localparam int TRTW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     req_valid;
    logic [2*NB-1:0]   req_cmd;
    logic [AW*NB-1:0]  req_addr;
    logic              block;
    logic [NB-1:0]     req_ready;
    logic              cmd_valid;
    logic [1:0]        cmd_code;
    logic [1:0]        cmd_bank;
    logic [AW-1:0]     cmd_addr;

    always #5 clk = ~clk;

    bank_cmd_arbiter #(
        .NUM_BANK(NB), .ADDR_W(AW), .TRRD(TRRD), .TWTR(TWTR), .TRTW(TRTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_addr(req_addr), .block(block), .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .cmd_addr(cmd_addr)
    );

    typedef struct {
        bit v;
        int code;
        int bank;
        int addr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference state: cycle numbers of the last accepted ACT/WR/RD and the bus contents.
    int m_ptr;
    int last_act, last_wr, last_rd;
    int m_code, m_bank, m_addr;

    logic [NB-1:0] b_valid;
    logic [1:0]    b_cmd  [NB];
    logic [AW-1:0] b_addr [NB];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_elig(input int c);
        case (c)
            0: return (cyc - last_act) >= TRRD;
            1: return (cyc - last_wr) >= TWTR;
            2: return (cyc - last_rd) >= TRTW;
            default: return 1'b1;
        endcase
    endfunction

    task automatic m_clear();
        m_ptr = 0;
        last_act = -1000; last_wr = -1000; last_rd = -1000;
        m_code = 0; m_bank = 0; m_addr = 0;
    endtask

    task automatic drive();
        req_valid = b_valid;
        for (int i = 0; i < NB; i++) begin
            req_cmd[2*i +: 2]   = b_cmd[i];
            req_addr[AW*i +: AW] = b_addr[i];
        end
    endtask

    // One clock: drive at negedge, check grant, push expected bus word, advance model.
    task automatic step(output int g, output logic [NB-1:0] rdy);
        exp_t e;
        logic [NB-1:0] exp_rdy;
        drive();
        #1;
        g = -1;
        if (rst_n && !block) begin
            for (int k = 0; k < NB; k++) begin
                int b;
                b = (m_ptr + k) % NB;
                if (g < 0 && b_valid[b] && m_elig(int'(b_cmd[b]))) g = b;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rdy = req_ready;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        e.v = 1'b0;
        if (!rst_n) begin
            m_clear();
        end else if (g >= 0) begin
            e.v    = 1'b1;
            m_code = int'(b_cmd[g]);
            m_bank = g;
            m_addr = int'(b_addr[g]);
            m_ptr  = (g + 1) % NB;
            if (m_code == 0) last_act = cyc;
            if (m_code == 1) last_rd  = cyc;
            if (m_code == 2) last_wr  = cyc;
        end
        e.code = m_code; e.bank = m_bank; e.addr = m_addr;
        q.push_back(e);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Monitor: compares the registered bus one step behind the stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("cmd_valid", int'(cmd_valid), int'(e.v));
            chk("cmd_code",  int'(cmd_code),  e.code);
            chk("cmd_bank",  int'(cmd_bank),  e.bank);
            chk("cmd_addr",  int'(cmd_addr),  e.addr);
        end
    end

    int            g;
    logic [NB-1:0] rdy;

    task automatic do_reset();
        rst_n = 1'b0; block = 1'b0; b_valid = '0;
        step(g, rdy);
        step(g, rdy);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int b, input logic [1:0] c, input int a);
        b_valid[b] = 1'b1; b_cmd[b] = c; b_addr[b] = AW'(a);
    endtask

    initial begin
        m_clear();
        b_valid = '0;
        for (int i = 0; i < NB; i++) begin b_cmd[i] = 2'b11; b_addr[i] = '0; end
        rst_n = 1'b0; block = 1'b0;

        // All banks PRE: strict rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NB; i++) set_req(i, 2'b11, 16 + i);
        step(g, rdy); chk("rr0", int'(rdy), 1);
        step(g, rdy); chk("rr1", int'(rdy), 2);
        step(g, rdy); chk("rr2", int'(rdy), 4);
        step(g, rdy); chk("rr3", int'(rdy), 8);
        step(g, rdy); chk("rr4", int'(rdy), 1);
        b_valid = '0; step(g, rdy);

        // ACT to ACT spacing.
        do_reset();
        set_req(0, 2'b00, 100); set_req(1, 2'b00, 101);
        step(g, rdy); chk("act0", int'(rdy), 1);
        b_valid[0] = 1'b0;
        for (int i = 0; i < TRRD - 1; i++) begin step(g, rdy); chk("act_hold", int'(rdy), 0); end
        step(g, rdy); chk("act1", int'(rdy), 2);
        b_valid = '0; step(g, rdy);

        // WR to RD turnaround while PRE slips through.
        do_reset();
        set_req(2, 2'b10, 200);
        step(g, rdy); chk("wr", int'(rdy), 4);
        b_valid[2] = 1'b0; set_req(3, 2'b01, 203); set_req(1, 2'b11, 201);
        step(g, rdy); chk("pre_skip", int'(rdy), 2);
        b_valid[1] = 1'b0;
        for (int i = 0; i < TWTR - 2; i++) begin step(g, rdy); chk("rd_hold", int'(rdy), 0); end
        step(g, rdy); chk("rd", int'(rdy), 8);
        b_valid = '0; step(g, rdy);

        // Block window holds grants; pointer untouched.
        do_reset();
        set_req(0, 2'b11, 300); set_req(2, 2'b11, 302);
        block = 1'b1;
        for (int i = 0; i < 5; i++) begin step(g, rdy); chk("blocked", int'(rdy), 0); end
        block = 1'b0;
        step(g, rdy); chk("blk_resume", int'(rdy), 1);
        b_valid[0] = 1'b0;
        step(g, rdy); chk("blk_next", int'(rdy), 4);
        b_valid = '0; step(g, rdy);

        // Reset in a grant cycle: no grant, pointer back to 0.
        do_reset();
        set_req(1, 2'b11, 401);
        step(g, rdy); chk("pre_rst", int'(rdy), 2);
        b_valid[1] = 1'b0; set_req(2, 2'b11, 402);
        rst_n = 1'b0;
        step(g, rdy); chk("rst_gnt", int'(rdy), 0);
        rst_n = 1'b1; set_req(1, 2'b11, 411);
        step(g, rdy); chk("rst_ptr", int'(rdy), 2);
        b_valid = '0; step(g, rdy);

        // Cancelled request never reaches the bus.
        do_reset();
        set_req(0, 2'b00, 500);
        step(g, rdy); chk("act_c", int'(rdy), 1);
        b_valid[0] = 1'b0; set_req(3, 2'b00, 503);
        step(g, rdy); chk("cancel0", int'(rdy), 0);
        step(g, rdy); chk("cancel1", int'(rdy), 0);
        b_valid[3] = 1'b0;
        for (int i = 0; i < TRRD; i++) begin step(g, rdy); chk("cancel_idle", int'(rdy), 0); end

        // Random traffic against the model.
        g = -1;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            block = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NB; i++) begin
                if (b_valid[i] && g == i) b_valid[i] = 1'b0;
                if (!b_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, (1 << AW) - 1)));
                end else if ($urandom_range(0, 19) == 0) begin
                    b_valid[i] = 1'b0;
                end
            end
            step(g, rdy);
        end
        rst_n = 1'b1; block = 1'b0; b_valid = '0;
        step(g, rdy);
        step(g, rdy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
